// File: rtl/crc7_h45_serial_checker.sv
// crc7_h45_serial_checker
// Receive-side checker for MSB-first serial frames: DATA_BITS payload bits
// followed by 7 CRC bits (CRC7, x^7 + x^3 + 1, init 0). Reports a one-cycle
// done pulse with a pass/fail verdict, the parallel payload and received CRC.
// Optional feature macro: CRC7_CHK_ERR_CNT_EN adds a saturating 8-bit count
// of failed frames (err_count), cleared only by RSTn.
module crc7_h45_serial_checker #(
    parameter int unsigned DATA_BITS = 40
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic [DATA_BITS-1:0] rx_data,
    output logic [6:0]           rx_crc
`ifdef CRC7_CHK_ERR_CNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } state_e;

    localparam logic [7:0] LAST_DATA = 8'(DATA_BITS - 1);
    localparam logic [7:0] LAST_CRC  = 8'd6;

    state_e                 state_q;
    logic [7:0]             cnt_q;
    logic [6:0]             lfsr_q;
    logic [6:0]             cap_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ok_q;
    logic                   err_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic [6:0]             rx_crc_q;
`ifdef CRC7_CHK_ERR_CNT_EN
    logic [7:0]             err_cnt_q;
`endif

    logic [DATA_BITS-1:0]   shift_d;
    logic [6:0]             lfsr_d;
    logic [6:0]             cap_d;
    logic                   fb;
    logic                   crc_match;

    // Next values of the shift paths for the bit currently on in_bit.
    always_comb begin
        shift_d   = (shift_q << 1) | DATA_BITS'(in_bit);
        fb        = in_bit ^ lfsr_q[6];
        lfsr_d    = {lfsr_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        cap_d     = {cap_q[5:0], in_bit};
        crc_match = (cap_d == lfsr_q);
    end

    // Frame FSM: payload/LFSR accumulation, CRC capture and registered verdict.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_DATA;
            cnt_q     <= '0;
            lfsr_q    <= '0;
            cap_q     <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            rx_data_q <= '0;
            rx_crc_q  <= '0;
`ifdef CRC7_CHK_ERR_CNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
            if (clear) begin
                state_q <= ST_DATA;
                cnt_q   <= '0;
                lfsr_q  <= '0;
                cap_q   <= '0;
                busy_q  <= 1'b0;
            end else if (in_valid) begin
                case (state_q)
                    ST_DATA: begin
                        shift_q <= shift_d;
                        lfsr_q  <= lfsr_d;
                        busy_q  <= 1'b1;
                        if (cnt_q == LAST_DATA) begin
                            state_q <= ST_CRC;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    ST_CRC: begin
                        cap_q <= cap_d;
                        if (cnt_q == LAST_CRC) begin
                            done_q    <= 1'b1;
                            ok_q      <= crc_match;
                            err_q     <= !crc_match;
                            rx_data_q <= shift_q;
                            rx_crc_q  <= cap_d;
                            lfsr_q    <= '0;
                            cnt_q     <= '0;
                            state_q   <= ST_DATA;
                            busy_q    <= 1'b0;
`ifdef CRC7_CHK_ERR_CNT_EN
                            if (!crc_match && (err_cnt_q != 8'hFF)) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
`endif
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign crc_ok  = ok_q;
    assign crc_err = err_q;
    assign rx_data = rx_data_q;
    assign rx_crc  = rx_crc_q;
`ifdef CRC7_CHK_ERR_CNT_EN
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc7_h45_serial_checker.sv
// Testbench for crc7_h45_serial_checker: directed SD-command frames with
// literal expectations plus randomized frames (gaps, corruption, aborts)
// checked every cycle against a frame-level reference model.
module tb_crc7_h45_serial_checker;

    localparam int unsigned DB = 40;

    logic          CLK      = 1'b0;
    logic          RSTn     = 1'b0;
    logic          clear    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit   = 1'b0;
    logic          busy;
    logic          done;
    logic          crc_ok;
    logic          crc_err;
    logic [DB-1:0] rx_data;
    logic [6:0]    rx_crc;
`ifdef CRC7_CHK_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cyc[$];

    crc7_h45_serial_checker #(.DATA_BITS(DB)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .clear    (clear),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .busy     (busy),
        .done     (done),
        .crc_ok   (crc_ok),
        .crc_err  (crc_err),
        .rx_data  (rx_data),
        .rx_crc   (rx_crc)
`ifdef CRC7_CHK_ERR_CNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference CRC: remainder of payload * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_ref(input logic [DB-1:0] m);
        logic [DB+6:0] r;
        r = {m, 7'b0};
        for (int i = DB + 6; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: counts accepted bits, collects payload and CRC.
    int            m_k       = 0;
    logic [DB-1:0] m_pay     = '0;
    logic [6:0]    m_crc     = '0;
    logic          exp_busy  = 1'b0;
    logic          exp_done  = 1'b0;
    logic          exp_ok    = 1'b0;
    logic          exp_err   = 1'b0;
    logic [DB-1:0] exp_data  = '0;
    logic [6:0]    exp_crc   = '0;
    int            exp_ecnt  = 0;

    initial forever begin
        @(posedge CLK or negedge RSTn);
        if (!RSTn) begin
            m_k = 0; exp_busy = 0; exp_done = 0; exp_ok = 0; exp_err = 0;
            exp_data = '0; exp_crc = '0; exp_ecnt = 0;
        end else begin
            exp_done = 0; exp_ok = 0; exp_err = 0;
            if (clear) begin
                m_k = 0;
            end else if (in_valid) begin
                if (m_k < DB) m_pay = {m_pay[DB-2:0], in_bit};
                else          m_crc = {m_crc[5:0], in_bit};
                m_k++;
                if (m_k == DB + 7) begin
                    exp_done = 1;
                    exp_ok   = (crc7_ref(m_pay) == m_crc);
                    exp_err  = !exp_ok;
                    exp_data = m_pay;
                    exp_crc  = m_crc;
                    if (exp_err && exp_ecnt < 255) exp_ecnt++;
                    m_k = 0;
                end
            end
            exp_busy = (m_k != 0);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (RSTn) begin
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("done", 64'(done), 64'(exp_done));
            chk("crc_ok", 64'(crc_ok), 64'(exp_ok));
            chk("crc_err", 64'(crc_err), 64'(exp_err));
            chk("rx_data", 64'(rx_data), 64'(exp_data));
            chk("rx_crc", 64'(rx_crc), 64'(exp_crc));
`ifdef CRC7_CHK_ERR_CNT_EN
            chk("err_count", 64'(err_count), 64'(exp_ecnt));
`endif
            if (done === 1'b1) done_cyc.push_back(cyc);
        end
    end

    task automatic idle();
        @(negedge CLK);
        in_valid = 1'b0;
        clear    = 1'b0;
        in_bit   = 1'($urandom);
    endtask

    // Sends payload+CRC bits; clear_at >= 0 replaces that bit with a clear cycle.
    task automatic send_stream(input logic [DB+6:0] f, input int gap_max, input int clear_at);
        for (int j = 0; j < int'(DB) + 7; j++) begin
            repeat ($urandom_range(0, gap_max)) idle();
            @(negedge CLK);
            if (j == clear_at) begin
                clear    = 1'b1;
                in_valid = 1'($urandom);
                in_bit   = 1'($urandom);
                return;
            end
            clear    = 1'b0;
            in_valid = 1'b1;
            in_bit   = f[DB+6-j];
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0]   r;
        logic [DB-1:0] pay;
        logic [6:0]    c;
        int            n0;

        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rx_data", 64'(rx_data), 64'd0);
        chk("rst_rx_crc", 64'(rx_crc), 64'd0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        idle();

        // CMD0, continuous
        send_stream({40'h4000000000, 7'h4A}, 0, -1);
        idle();
        chk("cmd0_done", 64'(done), 64'd1);
        chk("cmd0_ok", 64'(crc_ok), 64'd1);
        chk("cmd0_data", 64'(rx_data), 64'h4000000000);
        chk("cmd0_crc", 64'(rx_crc), 64'h4A);
        idle();

        // CMD8 with random gaps
        send_stream({40'h48000001AA, 7'h43}, 3, -1);
        idle();
        chk("cmd8_done", 64'(done), 64'd1);
        chk("cmd8_ok", 64'(crc_ok), 64'd1);
        chk("cmd8_crc", 64'(rx_crc), 64'h43);
        idle();

        // CMD17 with corrupted CRC
        send_stream({40'h5100000000, 7'h2B}, 1, -1);
        idle();
        chk("cmd17_err", 64'(crc_err), 64'd1);
        chk("cmd17_ok", 64'(crc_ok), 64'd0);
        chk("cmd17_crc", 64'(rx_crc), 64'h2B);
`ifdef CRC7_CHK_ERR_CNT_EN
        chk("cmd17_errcnt", 64'(err_count), 64'd1);
`endif
        idle();

        // clear after 20 payload bits, then a full CMD0
        send_stream({40'h4000000000, 7'h4A}, 0, 20);
        idle();
        chk("clear_busy", 64'(busy), 64'd0);
        n0 = done_cyc.size();
        send_stream({40'h4000000000, 7'h4A}, 0, -1);
        idle();
        chk("clr_cmd0_ok", 64'(crc_ok), 64'd1);
        repeat (2) idle();
        chk("clr_one_done", 64'(done_cyc.size() - n0), 64'd1);

        // clear coincident with the final CRC bit
        n0 = done_cyc.size();
        send_stream({40'h4000000000, 7'h4A}, 0, int'(DB) + 6);
        repeat (3) idle();
        chk("clr_last_no_done", 64'(done_cyc.size() - n0), 64'd0);

        // back-to-back CMD0, CMD8
        n0 = done_cyc.size();
        send_stream({40'h4000000000, 7'h4A}, 0, -1);
        send_stream({40'h48000001AA, 7'h43}, 0, -1);
        repeat (3) idle();
        chk("b2b_count", 64'(done_cyc.size() - n0), 64'd2);
        if (done_cyc.size() >= n0 + 2)
            chk("b2b_spacing", 64'(done_cyc[n0+1] - done_cyc[n0]), 64'd47);

        // reset mid-CRC
        for (int j = 0; j < int'(DB) + 3; j++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_bit   = 1'($urandom);
        end
        #2 RSTn = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_ok", 64'(crc_ok), 64'd0);
        chk("arst_err", 64'(crc_err), 64'd0);
        chk("arst_rx_data", 64'(rx_data), 64'd0);
        chk("arst_rx_crc", 64'(rx_crc), 64'd0);
`ifdef CRC7_CHK_ERR_CNT_EN
        chk("arst_errcnt", 64'(err_count), 64'd0);
`endif
        in_valid = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        idle();
        send_stream({40'h5100000000, 7'h2A}, 0, -1);
        idle();
        chk("post_rst_ok", 64'(crc_ok), 64'd1);
        chk("post_rst_data", 64'(rx_data), 64'h5100000000);
        idle();

        // randomized frames
        for (int n = 0; n < 60; n++) begin
            r   = {$urandom, $urandom};
            pay = r[DB-1:0];
            c   = crc7_ref(pay);
            if ($urandom_range(0, 3) == 0) c = c ^ 7'($urandom_range(1, 127));
            send_stream({pay, c}, $urandom_range(0, 2),
                        ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DB + 6)) : -1);
            if ($urandom_range(0, 2) == 0) idle();
        end
        repeat (2) idle();

`ifdef CRC7_CHK_ERR_CNT_EN
        // saturation of the failed-frame counter
        for (int n = 0; n < 260; n++) send_stream({40'h4000000000, 7'h4B}, 0, -1);
        repeat (2) idle();
        chk("errcnt_sat", 64'(err_count), 64'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crc7_h45_serial_checker.md
# crc7_h45_serial_checker

Serial CRC7 frame checker that consumes the MSB-first bitstream produced by `crc7_h45_script_serial`: payload bits, then the 7 CRC bits. It recomputes CRC7 (x^7 + x^3 + 1, init 0) over the payload, captures the received CRC, and reports a one-cycle pass/fail verdict together with the parallel payload. It sits on the receive side of the serial link, feeding the command/response decoder.

## Interface
- `DATA_BITS`, default 40: payload bits per frame before the CRC. Legal range 1..255.
- `CLK` input 1: clock; all state changes on the rising edge.
- `RSTn` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous frame abort/restart; highest priority.
- `in_valid` input 1: `in_bit` is sampled on this edge.
- `in_bit` input 1: serial bit, MSB first.
- `busy` output 1: a frame is partially received (bit counter != 0 or state is CRC).
- `done` output 1: one-cycle pulse; frame complete.
- `crc_ok` output 1: valid with `done`; the received CRC equals the computed CRC.
- `crc_err` output 1: valid with `done`; the received CRC differs from the computed CRC.
- `rx_data` output DATA_BITS: last completed payload; updates with `done`.
- `rx_crc` output 7: last received CRC; updates with `done`.
- `err_count` output 8: only present with `CRC7_CHK_ERR_CNT_EN` (see Configuration).

## Operation
- State machine has two states, DATA and CRC. Reset state is DATA with bit counter 0.
- **DATA state**, on each `in_valid`:
  - Shift `in_bit` into the payload shift register.
  - LFSR update: `fb = in_bit ^ lfsr[6]`; `lfsr = {lfsr[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00)`.
  - Counter increments.
  - On the DATA_BITS-th bit, go to CRC with counter = 0.
- **CRC state**, on each `in_valid`:
  - Shift `in_bit` into the CRC capture register, MSB first. The LFSR is frozen.
  - On the 7th bit:
    - Register `done` = 1, `crc_ok` = (capture == lfsr), `crc_err` = !`crc_ok`.
    - Load `rx_data` and `rx_crc`.
    - Clear the LFSR and counter, and return to DATA.
    - Back-to-back frames need no gap cycle.
- `in_valid` low: no state, counter or LFSR change (stall). Stalls may occur at any bit position.
- `clear` high:
  - Next state is DATA; counter, LFSR and capture register go to 0.
  - Any concurrent `in_valid` bit is discarded.
  - No `done` is generated.
  - `rx_data`, `rx_crc` and `err_count` are held.
- `done`, `crc_ok` and `crc_err` are low on every cycle that is not a completion cycle.

## Timing
- Reset values: `busy` = 0, `done` = 0, `crc_ok` = 0, `crc_err` = 0, `rx_data` = 0, `rx_crc` = 0, `err_count` = 0. Reset mid-frame discards the frame.
- Latency: `done` is high in the cycle immediately after the edge that samples the last CRC bit. A frame of DATA_BITS+7 consecutive valid cycles yields `done` 1 cycle after the final bit.
- `busy` is registered:
  - Rises in the cycle after the first payload bit is accepted.
  - Falls in the same cycle `done` rises.
  - Falls in the cycle after `clear`.
- `clear` coincident with the final CRC bit: `clear` wins and no `done` is produced.
- `rx_data` and `rx_crc` are stable from `done` until the next `done`.

## Configuration
- `CRC7_CHK_ERR_CNT_EN` defined:
  - Adds the `err_count` port and register.
  - Increments by 1 on every `done` with `crc_err` = 1.
  - Saturates at 255.
  - Cleared only by `RSTn`.
- Not defined: the port and register are absent; all other behaviour is identical.

## Test plan
- CMD0 frame 0x40_00000000 followed by CRC 7'h4A, continuous `in_valid` -> `done` once 1 cycle after the last bit, `crc_ok` = 1, `rx_data` = 40'h4000000000, `rx_crc` = 7'h4A.
- CMD8 frame 0x48_000001AA followed by CRC 7'h43, with random `in_valid` gaps -> `crc_ok` = 1, `rx_crc` = 7'h43; no state change observed during the gaps.
- CMD17 frame 0x51_00000000 followed by corrupted CRC 7'h2B (correct value 7'h2A) -> `crc_err` = 1, `crc_ok` = 0, `rx_crc` = 7'h2B; with the macro defined, `err_count` = 1.
- `clear` asserted after 20 payload bits, then a full CMD0 frame -> exactly one `done`, with `crc_ok` = 1; `busy` is 0 in the cycle after `clear`.
- Two back-to-back frames (CMD0, then CMD8) with no idle cycle -> two `done` pulses exactly 47 cycles apart, both with `crc_ok` = 1.
- `RSTn` pulsed low mid-CRC -> all outputs return to 0 asynchronously; the next full frame checks correctly.
